tinyalu_wide: RTL and testbench

- Parametrised next-generation TinyALU datapath.
- Same start/done protocol and op encoding, plus:
  - configurable operand width and multiplier latency;
  - operand latching at accept;
  - two new ops (SUB, MAX);
  - a busy indicator and an illegal-op error flag.
- Sits behind the UVM driver/monitor as the DUT; the SVA checker binds to its ports.

---
 rtl/tinyalu_wide_pkg.sv | 26 ++
 rtl/tinyalu_wide_if.sv | 28 ++
 rtl/tinyalu_wide_mult.sv | 25 ++
 rtl/tinyalu_wide.sv | 107 ++++++++++
 tb/tb_tinyalu_wide.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/tinyalu_wide_pkg.sv
// Shared types and constants for the parametrised TinyALU datapath.
// Opcode and FSM state encodings are used by the top level, the bus interface users and the bench.
package tinyalu_wide_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_MUL = 3'b100,
    OP_SUB = 3'b101,
    OP_MAX = 3'b110,
    OP_ILL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int MUL_LAT_MIN = 2;
  localparam int MUL_LAT_MAX = 16;
  localparam int CNT_W       = $clog2(MUL_LAT_MAX + 1);

endpackage

// File: rtl/tinyalu_wide_if.sv
// Request/response bus between a TinyALU requester and the datapath.
// Handshake: the requester raises start with A/B/op and holds it until it sees done;
// the datapath accepts only in IDLE with op!=NOP, latches the operands, and pulses done
// for exactly one cycle with result (and err for illegal ops). start is ignored while busy/responding.
interface tinyalu_wide_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2:0]         op;
  logic               start;
  logic               done;
  logic               busy;
  logic               err;
  logic [2*WIDTH-1:0] result;

  modport master (
    output A, B, op, start,
    input  done, busy, err, result
  );

  modport slave (
    input  A, B, op, start,
    output done, busy, err, result
  );

endinterface

// File: rtl/tinyalu_wide_mult.sv
// Registered unsigned WIDTH x WIDTH multiplier; the product is valid the cycle after load
// and holds until the next load, which satisfies any MUL_LAT of 2 or more.
module tinyalu_wide_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;

  assign a_ext = {{WIDTH{1'b0}}, a};
  assign b_ext = {{WIDTH{1'b0}}, b};

  always_ff @(posedge clk) begin
    if (load) begin
      prod <= a_ext * b_ext;
    end
  end

endmodule

// File: rtl/tinyalu_wide.sv
// Parametrised TinyALU: single-cycle ADD/AND/XOR/SUB/MAX/illegal, multi-cycle MUL,
// operands latched at accept, busy while a MUL is in flight, err pulse for illegal op.
module tinyalu_wide
  import tinyalu_wide_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  tinyalu_wide_if.slave         bus,
  output state_e                dbg_state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

  state_e             state;
  state_e             state_n;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic               accept;
  op_e                op_in;
  op_e                op_q;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] alu_res;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] result_q;

  assign op_in = op_e'(bus.op);
  assign a_ext = {{WIDTH{1'b0}}, bus.A};
  assign b_ext = {{WIDTH{1'b0}}, bus.B};

  tinyalu_wide_mult #(.WIDTH(WIDTH)) u_mult (
    .clk  (clk),
    .load (accept && (op_in == OP_MUL)),
    .a    (bus.A),
    .b    (bus.B),
    .prod (prod)
  );

  // Single-cycle ops are evaluated straight from the inputs at accept, so the
  // registered result is already the latched-operand answer in the done cycle.
  always_comb begin
    alu_res = '0;
    case (op_in)
      OP_ADD:  alu_res = a_ext + b_ext;
      OP_AND:  alu_res = a_ext & b_ext;
      OP_XOR:  alu_res = a_ext ^ b_ext;
      OP_SUB:  alu_res = a_ext - b_ext;
      OP_MAX:  alu_res = (bus.A > bus.B) ? a_ext : b_ext;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start && (op_in != OP_NOP)) begin
          accept  = 1'b1;
          state_n = (op_in == OP_MUL) ? ST_MUL : ST_RESP;
          cnt_n   = CNT_W'(1);
        end
      end
      ST_MUL: begin
        // cnt equals the number of cycles spent in MUL, so leaving at MUL_LAT-1 gives done at accept+MUL_LAT
        if (cnt == CNT_LAST) begin
          state_n = ST_RESP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= OP_NOP;
      result_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        op_q <= op_in;
      end
      if (accept && (op_in != OP_MUL)) begin
        result_q <= alu_res;
      end else if ((state == ST_MUL) && (state_n == ST_RESP)) begin
        result_q <= prod;
      end
    end
  end

  assign bus.done   = (state == ST_RESP);
  assign bus.busy   = (state == ST_MUL);
  assign bus.err    = (state == ST_RESP) && (op_q == OP_ILL);
  assign bus.result = result_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_tinyalu_wide.sv
// Directed self-checking bench for tinyalu_wide at WIDTH=8, MUL_LAT=4.
module tb_tinyalu_wide;
  import tinyalu_wide_pkg::*;

  logic   clk;
  logic   reset_n;
  state_e dbg_state;
  int     checks = 0;
  int     errors = 0;

  tinyalu_wide_if #(.WIDTH(8)) bus ();

  tinyalu_wide #(.WIDTH(8), .MUL_LAT(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o, input logic s);
    bus.A     = a;
    bus.B     = b;
    bus.op    = o;
    bus.start = s;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(8'h00, 8'h00, 3'b000, 1'b0);
    tick();
    tick();
    chk("rst_done",   32'(bus.done),   32'd0);
    chk("rst_busy",   32'(bus.busy),   32'd0);
    chk("rst_err",    32'(bus.err),    32'd0);
    chk("rst_result", 32'(bus.result), 32'h0);
    chk("rst_state",  32'(dbg_state),  32'(ST_IDLE));
    reset_n = 1'b1;
    tick();

    // ADD carry
    drive(8'hFF, 8'h01, 3'b001, 1'b1);
    tick();
    chk("add_done",   32'(bus.done),   32'd1);
    chk("add_result", 32'(bus.result), 32'h0100);
    chk("add_err",    32'(bus.err),    32'd0);
    chk("add_busy",   32'(bus.busy),   32'd0);
    bus.start = 1'b0;
    tick();
    chk("add_done_off", 32'(bus.done),   32'd0);
    chk("add_hold",     32'(bus.result), 32'h0100);

    // SUB wrap
    drive(8'h03, 8'h05, 3'b101, 1'b1);
    tick();
    chk("sub_done",   32'(bus.done),   32'd1);
    chk("sub_result", 32'(bus.result), 32'hFFFE);
    bus.start = 1'b0;
    tick();

    // AND
    drive(8'hF0, 8'h3C, 3'b010, 1'b1);
    tick();
    chk("and_done",   32'(bus.done),   32'd1);
    chk("and_result", 32'(bus.result), 32'h0030);
    bus.start = 1'b0;
    tick();

    // MUL with inputs changing after accept and start held
    drive(8'hFF, 8'hFF, 3'b100, 1'b1);
    tick();
    chk("mul_busy1", 32'(bus.busy), 32'd1);
    chk("mul_done1", 32'(bus.done), 32'd0);
    drive(8'h01, 8'h02, 3'b001, 1'b1);
    tick();
    chk("mul_busy2", 32'(bus.busy), 32'd1);
    chk("mul_done2", 32'(bus.done), 32'd0);
    tick();
    chk("mul_busy3", 32'(bus.busy), 32'd1);
    chk("mul_done3", 32'(bus.done), 32'd0);
    tick();
    chk("mul_done4",   32'(bus.done),   32'd1);
    chk("mul_busy4",   32'(bus.busy),   32'd0);
    chk("mul_result",  32'(bus.result), 32'hFE01);
    chk("mul_err",     32'(bus.err),    32'd0);
    bus.start = 1'b0;
    tick();
    chk("mul_done5",  32'(bus.done),   32'd0);
    chk("mul_state5", 32'(dbg_state),  32'(ST_IDLE));
    tick();
    chk("mul_done6",  32'(bus.done),   32'd0);
    chk("mul_hold",   32'(bus.result), 32'hFE01);

    // Illegal op
    drive(8'h05, 8'h06, 3'b111, 1'b1);
    tick();
    chk("ill_done",   32'(bus.done),   32'd1);
    chk("ill_err",    32'(bus.err),    32'd1);
    chk("ill_result", 32'(bus.result), 32'h0000);
    bus.start = 1'b0;
    tick();
    chk("ill_err_off",  32'(bus.err),  32'd0);
    chk("ill_done_off", 32'(bus.done), 32'd0);

    // NOP never accepted
    drive(8'h77, 8'h11, 3'b000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("nop_done", 32'(bus.done), 32'd0);
    end
    chk("nop_result", 32'(bus.result), 32'h0000);
    bus.start = 1'b0;
    tick();

    // Back-to-back XOR then MAX
    drive(8'hAA, 8'h0F, 3'b011, 1'b1);
    tick();
    chk("xor_done",   32'(bus.done),   32'd1);
    chk("xor_result", 32'(bus.result), 32'h00A5);
    drive(8'h12, 8'h34, 3'b110, 1'b1);
    tick();
    chk("b2b_idle_done", 32'(bus.done), 32'd0);
    tick();
    chk("max_done",   32'(bus.done),   32'd1);
    chk("max_result", 32'(bus.result), 32'h0034);
    bus.start = 1'b0;
    tick();

    // Reset mid-MUL
    drive(8'h10, 8'h10, 3'b100, 1'b1);
    tick();
    chk("rmul_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    chk("rmul_done",   32'(bus.done),   32'd0);
    chk("rmul_busy0",  32'(bus.busy),   32'd0);
    chk("rmul_result", 32'(bus.result), 32'h0000);
    chk("rmul_state",  32'(dbg_state),  32'(ST_IDLE));
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rmul_no_done", 32'(bus.done), 32'd0);
      chk("rmul_no_busy", 32'(bus.busy), 32'd0);
    end
    chk("rmul_result_end", 32'(bus.result), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
